fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of the team's asynchronous FIFO among `N_REQ` requesters in the write clock domain. Each requester streams words with a valid/ready/last handshake. The arbiter locks the grant for a whole packet, capped at `MAX_BURST` words, and drives the FIFO's `wr_en`/`wr_data` while honouring the FIFO `full` flag. It sits directly in front of the FIFO write side and is the only agent allowed to assert `wr_en`.

---
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the async FIFO write port among N_REQ requesters.
// A grant is held for a whole packet, capped at MAX_BURST words, and stalls while the FIFO is full.
module fifo_wr_arbiter #(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 16,
    localparam int IDW       = $clog2(N_REQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                     wclk,
    input  logic                     w_rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     full,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wr_data,
    output logic                     grant_valid,
    output logic [IDW-1:0]           grant_id,
    output logic [CW-1:0]            burst_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [CW-1:0]  burst_cnt_q, burst_cnt_d;

    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           any_valid;
    logic           release_hit;
    int             idx;

    // Scan from the highest offset down so the lowest offset from rr_ptr_q wins last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDW'(idx);
            if (req_valid[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = req_data[int'(grant_id_q)*WIDTH +: WIDTH];
        if (state_q == ST_BURST && w_rst_n) begin
            req_ready[grant_id_q] = ~full;
            wr_en                 = req_valid[grant_id_q] & ~full;
        end
    end

    assign release_hit = req_last[grant_id_q] | (burst_cnt_q == CW'(MAX_BURST - 1));

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d     = ST_BURST;
                    grant_id_d  = winner;
                    burst_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (wr_en) begin
                    if (release_hit) begin
                        state_d     = ST_IDLE;
                        burst_cnt_d = '0;
                        rr_ptr_d    = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
                    end else begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge wclk) begin
        if (!w_rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant_valid = (state_q == ST_BURST);
    assign grant_id    = grant_id_q;
    assign burst_cnt   = burst_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: packet-level sources, a cycle model of the
// arbitration rules compared every cycle, and hand-computed write/grant timelines per scenario.
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MB  = 16;
    localparam int IDW = 2;
    localparam int CW  = 5;

    logic             wclk = 1'b0;
    logic             w_rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             full;
    logic             wr_en;
    logic [W-1:0]     wr_data;
    logic             grant_valid;
    logic [IDW-1:0]   grant_id;
    logic [CW-1:0]    burst_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .wclk        (wclk),
        .w_rst_n     (w_rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .full        (full),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .burst_cnt   (burst_cnt)
    );

    always #5 wclk = ~wclk;

    // Per-requester source queues of {last, data}.
    logic [8:0] srcq [N][$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit full_ctl = 1'b0;
    bit rst_ctl  = 1'b0;
    bit model_ok = 1'b0;
    bit prev_gv  = 1'b0;

    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_ptr   = 0;

    logic [7:0] wlog_d [$];
    int         wlog_c [$];
    int         glog_id [$];
    int         glog_c  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit last);
        srcq[i].push_back({last, d});
    endtask

    task automatic clear_logs();
        wlog_d.delete(); wlog_c.delete(); glog_id.delete(); glog_c.delete();
    endtask

    task automatic expect_write(input int k, input logic [7:0] d, input int c);
        if (k < wlog_d.size()) begin
            check($sformatf("write%0d data", k), wlog_d[k], d);
            check($sformatf("write%0d cycle", k), wlog_c[k], c);
        end else begin
            check($sformatf("write%0d present", k), 0, 1);
        end
    endtask

    task automatic expect_grant(input int k, input int id, input int c);
        if (k < glog_id.size()) begin
            check($sformatf("grant%0d id", k), glog_id[k], id);
            check($sformatf("grant%0d cycle", k), glog_c[k], c);
        end else begin
            check($sformatf("grant%0d present", k), 0, 1);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare against the model, then advance it.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            bit           e_wr;
            logic [N-1:0] e_rdy;
            @(negedge wclk);
            w_rst_n = rst_ctl;
            full    = full_ctl;
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*W +: W] = srcq[i][0][7:0];
                    req_last[i]        = srcq[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[i*W +: W] = '0;
                    req_last[i]        = 1'b0;
                end
            end
            #1;
            e_wr  = 1'b0;
            e_rdy = '0;
            if (rst_ctl && model_ok && m_busy) begin
                if (!full_ctl) e_rdy[m_owner] = 1'b1;
                e_wr = req_valid[m_owner] && !full_ctl;
            end
            check("wr_en", wr_en, e_wr);
            check("req_ready", req_ready, e_rdy);
            if (model_ok) begin
                check("grant_valid", grant_valid, m_busy);
                check("burst_cnt", burst_cnt, m_cnt);
                if (m_busy) check("grant_id", grant_id, m_owner);
                if (e_wr) check("wr_data", wr_data, srcq[m_owner][0][7:0]);
            end

            if (wr_en) begin
                wlog_d.push_back(wr_data);
                wlog_c.push_back(cyc);
            end
            if (grant_valid && !prev_gv) begin
                glog_id.push_back(int'(grant_id));
                glog_c.push_back(cyc);
            end
            prev_gv = grant_valid;

            if (!rst_ctl) begin
                m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0; model_ok = 1'b1;
            end else if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    automatic int j = (m_ptr + k) % N;
                    if (req_valid[j]) begin
                        m_owner = j; m_busy = 1'b1; m_cnt = 0;
                        break;
                    end
                end
            end else if (e_wr) begin
                if (req_last[m_owner] || (m_cnt + 1 == MB)) begin
                    m_busy = 1'b0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
                end else begin
                    m_cnt++;
                end
            end

            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) void'(srcq[i].pop_front());
            cyc++;
        end
    endtask

    initial begin
        int t0;
        req_valid = '0; req_data = '0; req_last = '0; full = 1'b0; w_rst_n = 1'b0;

        // Reset state
        rst_ctl = 1'b0;
        run(3);
        rst_ctl = 1'b1;
        run(1);
        check("reset grant_valid", grant_valid, 0);
        check("reset grant_id", grant_id, 0);
        check("reset burst_cnt", burst_cnt, 0);
        check("reset wr_en", wr_en, 0);

        // Single 3-word packet from requester 1
        clear_logs();
        t0 = cyc;
        push(1, 8'hA1, 0); push(1, 8'hA2, 0); push(1, 8'hA3, 1);
        run(8);
        check("single nwrites", wlog_d.size(), 3);
        expect_write(0, 8'hA1, t0 + 1);
        expect_write(1, 8'hA2, t0 + 2);
        expect_write(2, 8'hA3, t0 + 3);
        expect_grant(0, 1, t0 + 1);

        // Contention straight after reset
        rst_ctl = 1'b0;
        run(2);
        rst_ctl = 1'b1;
        clear_logs();
        t0 = cyc;
        for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1);
        run(10);
        check("contend nwrites", wlog_d.size(), 4);
        for (int i = 0; i < N; i++) begin
            expect_write(i, 8'(8'h10 + i), t0 + 1 + 2*i);
            expect_grant(i, i, t0 + 1 + 2*i);
        end

        // Rotation: after requester 2, requester 3 beats requester 0
        clear_logs();
        t0 = cyc;
        push(2, 8'h22, 1);
        run(3);
        push(0, 8'h30, 1); push(3, 8'h33, 1);
        run(8);
        check("rotate nwrites", wlog_d.size(), 3);
        expect_write(0, 8'h22, t0 + 1);
        expect_write(1, 8'h33, t0 + 4);
        expect_write(2, 8'h30, t0 + 6);

        // Backpressure mid-packet
        clear_logs();
        t0 = cyc;
        for (int i = 0; i < 4; i++) push(1, 8'(8'h41 + i), i == 3);
        run(2);
        full_ctl = 1'b1;
        run(5);
        check("full burst_cnt frozen", burst_cnt, 1);
        check("full wr_en", wr_en, 0);
        full_ctl = 1'b0;
        run(6);
        check("bp nwrites", wlog_d.size(), 4);
        expect_write(0, 8'h41, t0 + 1);
        expect_write(1, 8'h42, t0 + 7);
        expect_write(2, 8'h43, t0 + 8);
        expect_write(3, 8'h44, t0 + 9);

        // Burst cap: 20 words from requester 0, one word from requester 1
        clear_logs();
        t0 = cyc;
        for (int i = 0; i < 20; i++) push(0, 8'(i + 1), i == 19);
        push(1, 8'h55, 1);
        run(28);
        check("cap nwrites", wlog_d.size(), 21);
        for (int i = 0; i < 16; i++) expect_write(i, 8'(i + 1), t0 + 1 + i);
        expect_write(16, 8'h55, t0 + 18);
        for (int i = 0; i < 4; i++) expect_write(17 + i, 8'(17 + i), t0 + 20 + i);
        expect_grant(1, 1, t0 + 18);
        expect_grant(2, 0, t0 + 20);

        // Reset during word 2 of 4
        clear_logs();
        t0 = cyc;
        for (int i = 0; i < 4; i++) push(2, 8'(8'h61 + i), i == 3);
        push(0, 8'h70, 1);
        run(2);
        rst_ctl = 1'b0;
        run(1);
        check("reset-cycle wr_en", wr_en, 0);
        check("reset-cycle req_ready", req_ready, 0);
        rst_ctl = 1'b1;
        run(1);
        check("post-reset grant_valid", grant_valid, 0);
        run(9);
        check("rst nwrites", wlog_d.size(), 5);
        expect_write(0, 8'h61, t0 + 1);
        expect_write(1, 8'h70, t0 + 4);
        expect_write(2, 8'h62, t0 + 6);
        expect_write(3, 8'h63, t0 + 7);
        expect_write(4, 8'h64, t0 + 8);
        expect_grant(1, 0, t0 + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
